// File: rtl/control_sequencer_pkg.sv
// Shared types for the 8-bit CPU control sequencer: opcodes, micro-step
// constants and the packed control word driven to every bus agent.
package cpu_ctrl_pkg;

  // Step counter width, $clog2(5) for the five micro-steps T0..T4.
  localparam int STEP_W = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // Bit order (MSB first) is also the order the bench packs the ports in.
  typedef struct packed {
    logic hlt;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
    logic pc_inc;
    logic pc_out;
    logic pc_jump;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = 16'h0000;

endpackage

// File: rtl/control_sequencer_checker.sv
// Protocol checker for the control sequencer outputs: bus single-driver,
// PC increment/jump exclusivity and IR load confined to T1.
module control_sequencer_checker
  import cpu_ctrl_pkg::*;
(
  input logic              clk,
  input logic [STEP_W-1:0] step,
  input ctrl_word_t        ctrl
);

  a_bus_single_driver: assert property (@(posedge clk)
    $onehot0({ctrl.pc_out, ctrl.ram_out, ctrl.ir_out, ctrl.a_out, ctrl.alu_out}))
    else $error("FAIL bus_single_driver ctrl=%h", ctrl);

  a_inc_jump_exclusive: assert property (@(posedge clk) !(ctrl.pc_inc && ctrl.pc_jump))
    else $error("FAIL inc_jump_exclusive ctrl=%h", ctrl);

  a_ir_in_t1_only: assert property (@(posedge clk) !ctrl.ir_in || (step == T1))
    else $error("FAIL ir_in_t1_only step=%0d", step);

endmodule

// File: rtl/control_sequencer_rom.sv
// Microcode decode: (opcode, step, flags) -> control word, plus a flag that
// marks the last step doing useful work for the current instruction.
module control_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output ctrl_word_t        ctrl,
  output logic              last_step
);

  // Purely combinational microcode table; flags only matter for JC/JZ.
  always_comb begin
    ctrl      = CTRL_NONE;
    last_step = 1'b0;
    case (step)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      T1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA,
          OP_LDI, OP_JMP, OP_OUT, OP_HLT: last_step = 1'b0;
          OP_JC:   last_step = ~carry_flag;
          OP_JZ:   last_step = ~zero_flag;
          default: last_step = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      T2: begin
        last_step = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
            last_step   = 1'b0;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_jump = 1'b1;
          end
          OP_JC: begin
            ctrl.ir_out  = carry_flag;
            ctrl.pc_jump = carry_flag;
          end
          OP_JZ: begin
            ctrl.ir_out  = zero_flag;
            ctrl.pc_jump = zero_flag;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
          end
          OP_HLT: ctrl.hlt = 1'b1;
          default: ctrl = CTRL_NONE;
        endcase
      end
      T3: begin
        last_step = 1'b1;
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
            last_step    = 1'b0;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      T4: begin
        last_step = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB: begin
            ctrl.alu_out  = 1'b1;
            ctrl.a_in     = 1'b1;
            ctrl.flags_in = 1'b1;
            ctrl.alu_sub  = (opcode == OP_SUB);
          end
          default: ctrl = CTRL_NONE;
        endcase
      end
      default: last_step = 1'b1;  // unreachable steps recover to T0
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer top: micro-step counter, halt latch, reset forcing of the
// control lines and unpacking of the microcode word onto individual ports.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [STEP_W-1:0] step,
  output logic              hlt,
  output logic              mar_in,
  output logic              ram_in,
  output logic              ram_out,
  output logic              ir_in,
  output logic              ir_out,
  output logic              a_in,
  output logic              a_out,
  output logic              b_in,
  output logic              alu_out,
  output logic              alu_sub,
  output logic              flags_in,
  output logic              out_in,
  output logic              pc_inc,
  output logic              pc_out,
  output logic              pc_jump
);

  localparam logic [STEP_W-1:0] LAST_STEP = 3'(NUM_STEPS - 1);

  logic [STEP_W-1:0] step_q;
  logic              halted;
  logic              last_step;
  ctrl_word_t        rom_ctrl;
  ctrl_word_t        ctrl;

  control_rom u_rom (
    .opcode     (opcode),
    .step       (step_q),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (rom_ctrl),
    .last_step  (last_step)
  );

  // Advance the micro-step; HLT freezes the counter at T2 until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= T0;
      halted <= 1'b0;
    end else if (halted) begin
      step_q <= step_q;
      halted <= 1'b1;
    end else if (rom_ctrl.hlt) begin
      step_q <= step_q;
      halted <= 1'b1;
    end else if ((EARLY_END && last_step) || (step_q == LAST_STEP)) begin
      step_q <= T0;
    end else begin
      step_q <= step_q + 3'd1;
    end
  end

  // Reset silences every line; once halted only hlt stays asserted.
  always_comb begin
    ctrl = CTRL_NONE;
    if (rst) begin
      ctrl = CTRL_NONE;
    end else if (halted) begin
      ctrl.hlt = 1'b1;
    end else begin
      ctrl = rom_ctrl;
    end
  end

  assign step     = step_q;
  assign hlt      = ctrl.hlt;
  assign mar_in   = ctrl.mar_in;
  assign ram_in   = ctrl.ram_in;
  assign ram_out  = ctrl.ram_out;
  assign ir_in    = ctrl.ir_in;
  assign ir_out   = ctrl.ir_out;
  assign a_in     = ctrl.a_in;
  assign a_out    = ctrl.a_out;
  assign b_in     = ctrl.b_in;
  assign alu_out  = ctrl.alu_out;
  assign alu_sub  = ctrl.alu_sub;
  assign flags_in = ctrl.flags_in;
  assign out_in   = ctrl.out_in;
  assign pc_inc   = ctrl.pc_inc;
  assign pc_out   = ctrl.pc_out;
  assign pc_jump  = ctrl.pc_jump;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: table of per-cycle vectors for the
// EARLY_END=1 instance, hand sequences for reset/halt/full-length stepping,
// and a random sweep checking the bus invariants on both instances.
module tb_control_sequencer;

  localparam logic [15:0] M_HLT      = 16'h8000;
  localparam logic [15:0] M_MAR_IN   = 16'h4000;
  localparam logic [15:0] M_RAM_IN   = 16'h2000;
  localparam logic [15:0] M_RAM_OUT  = 16'h1000;
  localparam logic [15:0] M_IR_IN    = 16'h0800;
  localparam logic [15:0] M_IR_OUT   = 16'h0400;
  localparam logic [15:0] M_A_IN     = 16'h0200;
  localparam logic [15:0] M_A_OUT    = 16'h0100;
  localparam logic [15:0] M_B_IN     = 16'h0080;
  localparam logic [15:0] M_ALU_OUT  = 16'h0040;
  localparam logic [15:0] M_ALU_SUB  = 16'h0020;
  localparam logic [15:0] M_FLAGS_IN = 16'h0010;
  localparam logic [15:0] M_OUT_IN   = 16'h0008;
  localparam logic [15:0] M_PC_INC   = 16'h0004;
  localparam logic [15:0] M_PC_OUT   = 16'h0002;
  localparam logic [15:0] M_PC_JUMP  = 16'h0001;
  localparam logic [15:0] NONE       = 16'h0000;
  localparam logic [15:0] F0 = M_PC_OUT | M_MAR_IN;
  localparam logic [15:0] F1 = M_RAM_OUT | M_IR_IN | M_PC_INC;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  wire  [2:0]  ee_step, fu_step;
  wire  [15:0] ee_w, fu_w;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) u_ee (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step(ee_step), .hlt(ee_w[15]), .mar_in(ee_w[14]), .ram_in(ee_w[13]), .ram_out(ee_w[12]),
    .ir_in(ee_w[11]), .ir_out(ee_w[10]), .a_in(ee_w[9]), .a_out(ee_w[8]), .b_in(ee_w[7]),
    .alu_out(ee_w[6]), .alu_sub(ee_w[5]), .flags_in(ee_w[4]), .out_in(ee_w[3]),
    .pc_inc(ee_w[2]), .pc_out(ee_w[1]), .pc_jump(ee_w[0]));

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) u_fu (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step(fu_step), .hlt(fu_w[15]), .mar_in(fu_w[14]), .ram_in(fu_w[13]), .ram_out(fu_w[12]),
    .ir_in(fu_w[11]), .ir_out(fu_w[10]), .a_in(fu_w[9]), .a_out(fu_w[8]), .b_in(fu_w[7]),
    .alu_out(fu_w[6]), .alu_sub(fu_w[5]), .flags_in(fu_w[4]), .out_in(fu_w[3]),
    .pc_inc(fu_w[2]), .pc_out(fu_w[1]), .pc_jump(fu_w[0]));

  control_sequencer_checker u_chk_ee (.clk(clk), .step(ee_step), .ctrl(ee_w));
  control_sequencer_checker u_chk_fu (.clk(clk), .step(fu_step), .ctrl(fu_w));

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  st;
    logic [15:0] ctl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] op, input logic c, input logic z,
                              input logic [2:0] st, input logic [15:0] ctl);
    vec_t v;
    v.op = op; v.c = c; v.z = z; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endfunction

  function automatic void add_fetch(input logic [3:0] op, input logic c, input logic z);
    add(op, c, z, 3'd0, F0);
    add(op, c, z, 3'd1, F1);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_inv(input string name, input logic [2:0] st, input logic [15:0] w);
    logic ok;
    logic [4:0] drv;
    drv = {w[1], w[12], w[10], w[8], w[6]};
    ok  = ($countones(drv) <= 1) && !(w[2] && w[0]) && (!w[11] || (st == 3'd1));
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: step=%0d lines=%h violate bus/pc/ir rules", name, st, w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  fu_st_exp  [6];
  logic [15:0] fu_ctl_exp [6];

  initial begin
    rst = 1'b1; opcode = 4'd0; carry_flag = 1'b0; zero_flag = 1'b0;

    // LDI, OUT, ADD, SUB, LDA, STA, JMP, JC/JZ both ways, NOP, undefined, LDI
    add_fetch(4'h5, 1'b0, 1'b0); add(4'h5, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_A_IN);
    add_fetch(4'hE, 1'b0, 1'b0); add(4'hE, 1'b0, 1'b0, 3'd2, M_A_OUT | M_OUT_IN);
    add_fetch(4'h2, 1'b0, 1'b0); add(4'h2, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN);
    add(4'h2, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_B_IN);
    add(4'h2, 1'b0, 1'b0, 3'd4, M_ALU_OUT | M_A_IN | M_FLAGS_IN);
    add_fetch(4'h3, 1'b1, 1'b0); add(4'h3, 1'b1, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN);
    add(4'h3, 1'b1, 1'b0, 3'd3, M_RAM_OUT | M_B_IN);
    add(4'h3, 1'b1, 1'b0, 3'd4, M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_ALU_SUB);
    add_fetch(4'h1, 1'b0, 1'b0); add(4'h1, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN);
    add(4'h1, 1'b0, 1'b0, 3'd3, M_RAM_OUT | M_A_IN);
    add_fetch(4'h4, 1'b0, 1'b0); add(4'h4, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_MAR_IN);
    add(4'h4, 1'b0, 1'b0, 3'd3, M_A_OUT | M_RAM_IN);
    add_fetch(4'h6, 1'b0, 1'b0); add(4'h6, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_PC_JUMP);
    add_fetch(4'h7, 1'b0, 1'b1);
    add_fetch(4'h7, 1'b1, 1'b0); add(4'h7, 1'b1, 1'b0, 3'd2, M_IR_OUT | M_PC_JUMP);
    add_fetch(4'h8, 1'b1, 1'b0);
    add_fetch(4'h8, 1'b0, 1'b1); add(4'h8, 1'b0, 1'b1, 3'd2, M_IR_OUT | M_PC_JUMP);
    add_fetch(4'h0, 1'b1, 1'b1);
    add_fetch(4'hA, 1'b1, 1'b1);
    add_fetch(4'hD, 1'b0, 1'b0);
    add_fetch(4'h5, 1'b0, 1'b0); add(4'h5, 1'b0, 1'b0, 3'd2, M_IR_OUT | M_A_IN);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lines_ee", ee_w, NONE);
    chk("reset_lines_fu", fu_w, NONE);
    chk("reset_step", {13'd0, ee_step}, 16'd0);
    rst = 1'b0;

    // Table-driven per-cycle vectors
    foreach (vecs[i]) begin
      opcode = vecs[i].op; carry_flag = vecs[i].c; zero_flag = vecs[i].z;
      #1;
      chk($sformatf("vec%0d_step", i), {13'd0, ee_step}, {13'd0, vecs[i].st});
      chk($sformatf("vec%0d_lines", i), ee_w, vecs[i].ctl);
      tick();
    end

    // Reset held 2 cycles in the middle of ADD T3
    opcode = 4'h2; carry_flag = 1'b0; zero_flag = 1'b0;
    repeat (3) tick();
    chk("add_t3_step", {13'd0, ee_step}, 16'd3);
    chk("add_t3_lines", ee_w, M_RAM_OUT | M_B_IN);
    rst = 1'b1;
    #1;
    chk("midrst_c1_lines", ee_w, NONE);
    tick();
    chk("midrst_c2_lines", ee_w, NONE);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_step", {13'd0, ee_step}, 16'd0);
    chk("post_rst_lines", ee_w, F0);

    // HLT: both instances halt in T2 and stay there regardless of opcode
    opcode = 4'hF;
    repeat (2) tick();
    chk("hlt_t2_step", {13'd0, ee_step}, 16'd2);
    chk("hlt_t2_lines", ee_w, M_HLT);
    for (int k = 0; k < 20; k++) begin
      tick();
      opcode = 4'h5;
      #1;
      chk($sformatf("halted%0d_step", k), {13'd0, ee_step}, 16'd2);
      chk($sformatf("halted%0d_lines", k), ee_w, M_HLT);
      chk($sformatf("halted%0d_fu_lines", k), fu_w, M_HLT);
    end
    rst = 1'b1;
    #1;
    chk("hlt_rst_lines", ee_w, NONE);
    tick();
    rst = 1'b0;
    #1;
    chk("hlt_resume_step", {13'd0, ee_step}, 16'd0);
    chk("hlt_resume_lines", ee_w, F0);

    // EARLY_END=0: LDI runs all five steps, then JC not taken also runs five
    fu_st_exp  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    fu_ctl_exp = '{F0, F1, M_IR_OUT | M_A_IN, NONE, NONE, F0};
    opcode = 4'h5;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("full_ldi%0d_step", k), {13'd0, fu_step}, {13'd0, fu_st_exp[k]});
      chk($sformatf("full_ldi%0d_lines", k), fu_w, fu_ctl_exp[k]);
      tick();
    end
    fu_ctl_exp = '{F1, NONE, NONE, NONE, F0, F1};
    fu_st_exp  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    opcode = 4'h7; carry_flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("full_jc%0d_step", k), {13'd0, fu_step}, {13'd0, fu_st_exp[k]});
      chk($sformatf("full_jc%0d_lines", k), fu_w, fu_ctl_exp[k]);
      tick();
    end

    // Random sweep: invariants on both instances
    for (int k = 0; k < 10000; k++) begin
      opcode     = 4'($urandom_range(0, 14));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 99) == 0);
      #1;
      chk_inv("sweep_ee", ee_step, ee_w);
      chk_inv("sweep_fu", fu_step, fu_w);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
